// File: rtl/sc_fifo_serializer.sv
// Slow-control FIFO consumer: pops configuration bytes from the external FIFO and
// shifts them MSB-first into the ASIC slow-control chain with a divided shift clock.
module sc_fifo_serializer #(
    parameter int SC_NUM  = 77,
    parameter int CLK_DIV = 4,
    parameter int RST_CYC = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start_In,
    input  logic       In_Ex_Fifo_Empty,
    input  logic [7:0] In_Ex_Fifo_Dout,
    output logic       Out_Ex_Fifo_Rd_En,
    output logic       Out_Sr_Ck,
    output logic       Out_Sr_In,
    output logic       Out_Sr_Rstb,
    output logic       Out_Select,
    output logic       Out_Busy,
    output logic       Out_Err,
    output logic       End_Flag
);

    localparam int BYTE_W = $clog2(SC_NUM + 1);
    localparam int BIT_W  = 3;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RST_W  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(SC_NUM - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYC - 1);
    localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SR_RESET = 3'd1,
        FETCH    = 3'd2,
        LOAD     = 3'd3,
        SHIFT    = 3'd4,
        DONE     = 3'd5,
        ERR      = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic              start_in_q, start_in_d;
    logic              err_q, err_d;
    logic              phase_q, phase_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              start_pulse;

    assign start_pulse = Start_In & ~start_in_q;

    // State and datapath register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            start_in_q <= 1'b0;
            err_q      <= 1'b0;
            phase_q    <= 1'b0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            div_cnt_q  <= '0;
            rst_cnt_q  <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            start_in_q <= start_in_d;
            err_q      <= err_d;
            phase_q    <= phase_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            div_cnt_q  <= div_cnt_d;
            rst_cnt_q  <= rst_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d    = state_q;
        start_in_d = Start_In;
        err_d      = err_q;
        phase_d    = phase_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        div_cnt_d  = div_cnt_q;
        rst_cnt_d  = rst_cnt_q;
        to_cnt_d   = to_cnt_q;

        case (state_q)
            IDLE: begin
                if (start_pulse) begin
                    state_d    = SR_RESET;
                    err_d      = 1'b0;
                    byte_cnt_d = '0;
                    rst_cnt_d  = '0;
                    to_cnt_d   = '0;
                end
            end
            SR_RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    rst_cnt_d = '0;
                    state_d   = FETCH;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            FETCH: begin
                // Timeout counts only consecutive empty cycles since the last pop
                if (!In_Ex_Fifo_Empty) begin
                    to_cnt_d = '0;
                    state_d  = LOAD;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (to_cnt_d == TO_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end
                end
            end
            LOAD: begin
                shreg_d   = In_Ex_Fifo_Dout;
                bit_cnt_d = '0;
                div_cnt_d = '0;
                phase_d   = 1'b0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        // Data advances only as the shift clock falls, so Sr_In is
                        // stable for the whole high phase
                        phase_d   = 1'b0;
                        shreg_d   = {shreg_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                            state_d    = (byte_cnt_q == BYTE_LAST) ? DONE : FETCH;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        Out_Ex_Fifo_Rd_En = 1'b0;
        Out_Sr_Ck         = 1'b0;
        Out_Sr_In         = 1'b0;
        Out_Sr_Rstb       = 1'b1;
        Out_Select        = 1'b0;
        Out_Busy          = 1'b0;
        End_Flag          = 1'b0;
        case (state_q)
            SR_RESET: begin
                Out_Sr_Rstb = 1'b0;
                Out_Select  = 1'b1;
                Out_Busy    = 1'b1;
            end
            FETCH: begin
                Out_Ex_Fifo_Rd_En = ~In_Ex_Fifo_Empty;
                Out_Select        = 1'b1;
                Out_Busy          = 1'b1;
            end
            LOAD: begin
                Out_Select = 1'b1;
                Out_Busy   = 1'b1;
            end
            SHIFT: begin
                Out_Sr_Ck  = phase_q;
                Out_Sr_In  = shreg_q[7];
                Out_Select = 1'b1;
                Out_Busy   = 1'b1;
            end
            DONE:    End_Flag = 1'b1;
            default: ;
        endcase
    end

    assign Out_Err = err_q;

endmodule

// File: tb/tb_sc_fifo_serializer.sv
// Directed bench for sc_fifo_serializer: behavioural FIFO, shift-chain monitor and
// one task per scenario with inline checks against hand-computed values.
module tb_sc_fifo_serializer;

    localparam int SC_NUM  = 77;
    localparam int CLK_DIV = 4;
    localparam int RST_CYC = 8;
    localparam int TIMEOUT = 1024;
    localparam int BYTE_CYC = 2 + 16 * CLK_DIV;

    logic       Clk;
    logic       Rst;
    logic       Start_In;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       Out_Ex_Fifo_Rd_En;
    logic       Out_Sr_Ck;
    logic       Out_Sr_In;
    logic       Out_Sr_Rstb;
    logic       Out_Select;
    logic       Out_Busy;
    logic       Out_Err;
    logic       End_Flag;

    int errors = 0;
    int checks = 0;

    sc_fifo_serializer #(
        .SC_NUM (SC_NUM),
        .CLK_DIV(CLK_DIV),
        .RST_CYC(RST_CYC),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .Start_In         (Start_In),
        .In_Ex_Fifo_Empty (fifo_empty),
        .In_Ex_Fifo_Dout  (fifo_dout),
        .Out_Ex_Fifo_Rd_En(Out_Ex_Fifo_Rd_En),
        .Out_Sr_Ck        (Out_Sr_Ck),
        .Out_Sr_In        (Out_Sr_In),
        .Out_Sr_Rstb      (Out_Sr_Rstb),
        .Out_Select       (Out_Select),
        .Out_Busy         (Out_Busy),
        .Out_Err          (Out_Err),
        .End_Flag         (End_Flag)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural FIFO: data appears the cycle after the pop strobe
    logic [7:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge Clk) begin
        if (Out_Ex_Fifo_Rd_En) begin
            fifo_dout <= mem[rd_ptr % 1024];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Monitor, sampled 1 time unit after each rising clock edge
    logic bits [0:8191];
    int   rise_cnt = 0;
    int   end_cnt = 0;
    int   hi_change_cnt = 0;
    int   rd_empty_cnt = 0;
    int   pop_cnt = 0;
    logic prev_ck = 1'b0;
    logic prev_in = 1'b0;

    always @(posedge Clk) begin
        #1;
        if (Out_Sr_Ck && !prev_ck) begin
            bits[rise_cnt % 8192] <= Out_Sr_In;
            rise_cnt <= rise_cnt + 1;
        end
        if (Out_Sr_Ck && prev_ck && (Out_Sr_In !== prev_in)) hi_change_cnt <= hi_change_cnt + 1;
        if (End_Flag) end_cnt <= end_cnt + 1;
        if (Out_Ex_Fifo_Rd_En && fifo_empty) rd_empty_cnt <= rd_empty_cnt + 1;
        if (Out_Ex_Fifo_Rd_En) pop_cnt <= pop_cnt + 1;
        prev_ck <= Out_Sr_Ck;
        prev_in <= Out_Sr_In;
    end

    task automatic push(input logic [7:0] v);
        mem[wr_ptr % 1024] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic flush();
        wr_ptr = rd_ptr;
    endtask

    // Raise Start_In at the current negedge; returns at the negedge after detection
    task automatic start_pulse();
        Start_In = 1'b1;
        @(negedge Clk);
        Start_In = 1'b0;
    endtask

    task automatic wait_busy_low(input int budget, output int n, output bit timed_out);
        n = 0;
        while (Out_Busy && n < budget) begin
            @(negedge Clk);
            n++;
        end
        timed_out = Out_Busy;
    endtask

    task automatic wait_rises(input int target, input int rb, input int budget, output bit timed_out);
        int n;
        n = 0;
        while ((rise_cnt - rb) < target && n < budget) begin
            @(negedge Clk);
            n++;
        end
        timed_out = ((rise_cnt - rb) < target);
    endtask

    // Number of captured bits differing from the FIFO bytes, MSB first
    function automatic int bit_mismatches(input int rb, input int bb, input int nbytes);
        int m;
        logic [7:0] v;
        m = 0;
        for (int i = 0; i < nbytes; i++) begin
            v = mem[(bb + i) % 1024];
            for (int b = 0; b < 8; b++)
                if (bits[(rb + i * 8 + b) % 8192] !== v[7 - b]) m++;
        end
        return m;
    endfunction

    task automatic test_reset();
        Rst = 1'b1;
        Start_In = 1'b0;
        repeat (3) @(negedge Clk);
        checks++; if (Out_Ex_Fifo_Rd_En !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", Out_Ex_Fifo_Rd_En); end
        checks++; if (Out_Sr_Ck !== 1'b0) begin errors++; $display("FAIL reset_sr_ck: got %b expected 0", Out_Sr_Ck); end
        checks++; if (Out_Sr_In !== 1'b0) begin errors++; $display("FAIL reset_sr_in: got %b expected 0", Out_Sr_In); end
        checks++; if (Out_Sr_Rstb !== 1'b1) begin errors++; $display("FAIL reset_sr_rstb: got %b expected 1", Out_Sr_Rstb); end
        checks++; if (Out_Select !== 1'b0) begin errors++; $display("FAIL reset_select: got %b expected 0", Out_Select); end
        checks++; if (Out_Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Out_Busy); end
        checks++; if (Out_Err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", Out_Err); end
        checks++; if (End_Flag !== 1'b0) begin errors++; $display("FAIL reset_end_flag: got %b expected 0", End_Flag); end
        Rst = 1'b0;
        @(negedge Clk);
        $display("test_reset done");
    endtask

    task automatic test_full_load();
        int rb, bb, eb, hb, re, k, n, ones;
        bit to;
        flush();
        push(8'hFF);
        for (int i = 0; i < 76; i++) push(8'(i));
        rb = rise_cnt; bb = rd_ptr; eb = end_cnt; hb = hi_change_cnt; re = rd_empty_cnt;
        start_pulse();
        checks++; if ({Out_Busy, Out_Select} !== 2'b11) begin errors++; $display("FAIL full_busy_select_on_start: got %b expected 11", {Out_Busy, Out_Select}); end
        k = 1;
        while (!Out_Sr_Ck && k < 64) begin
            @(negedge Clk);
            k++;
        end
        checks++; if (k != 15) begin errors++; $display("FAIL full_first_rise_latency: got %0d expected 15", k); end
        wait_busy_low(8000, n, to);
        checks++; if (to) begin errors++; $display("FAIL full_timeout: busy still %b expected 0", Out_Busy); end
        checks++; if (k + n - 1 != 5090) begin errors++; $display("FAIL full_busy_cycles: got %0d expected 5090", k + n - 1); end
        checks++; if (End_Flag !== 1'b1) begin errors++; $display("FAIL full_end_flag_at_done: got %b expected 1", End_Flag); end
        @(negedge Clk);
        checks++; if (End_Flag !== 1'b0) begin errors++; $display("FAIL full_end_flag_one_cycle: got %b expected 0", End_Flag); end
        checks++; if (rise_cnt - rb != 616) begin errors++; $display("FAIL full_rises: got %0d expected 616", rise_cnt - rb); end
        ones = 0;
        for (int i = 0; i < 8; i++) if (bits[(rb + i) % 8192] === 1'b1) ones++;
        checks++; if (ones != 8) begin errors++; $display("FAIL full_first_byte_ones: got %0d expected 8", ones); end
        checks++; if (bit_mismatches(rb, bb, 77) != 0) begin errors++; $display("FAIL full_stream: got %0d bit errors expected 0", bit_mismatches(rb, bb, 77)); end
        checks++; if (end_cnt - eb != 1) begin errors++; $display("FAIL full_end_pulses: got %0d expected 1", end_cnt - eb); end
        checks++; if (Out_Err !== 1'b0) begin errors++; $display("FAIL full_err: got %b expected 0", Out_Err); end
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL full_fifo_empty: got %b expected 1", fifo_empty); end
        checks++; if (hi_change_cnt - hb != 0) begin errors++; $display("FAIL full_sr_in_change_while_ck_high: got %0d expected 0", hi_change_cnt - hb); end
        checks++; if (rd_empty_cnt - re != 0) begin errors++; $display("FAIL full_rd_en_while_empty: got %0d expected 0", rd_empty_cnt - re); end
        $display("test_full_load done: rises=%0d", rise_cnt - rb);
    endtask

    task automatic test_a5_waveform();
        logic ck_s [1:80];
        logic in_s [1:80];
        logic pat [0:7];
        int rb, eb, ck_mis, in_mis, j, n, pat_mis;
        bit to, exp_ck;
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        flush();
        push(8'hA5);
        for (int i = 0; i < 76; i++) push(8'h00);
        rb = rise_cnt; eb = end_cnt;
        start_pulse();
        for (int k = 1; k <= 80; k++) begin
            ck_s[k] = Out_Sr_Ck;
            in_s[k] = Out_Sr_In;
            @(negedge Clk);
        end
        // Shifting occupies cycles 11..74 after the start edge: 4 low + 4 high per bit
        ck_mis = 0; in_mis = 0;
        for (int k = 11; k <= 74; k++) begin
            j = (k - 11) / 8;
            exp_ck = (((k - 11) % 8) >= 4);
            if (ck_s[k] !== exp_ck) ck_mis++;
            if (in_s[k] !== pat[j]) in_mis++;
        end
        checks++; if (ck_mis != 0) begin errors++; $display("FAIL a5_sr_ck_shape: got %0d wrong cycles expected 0", ck_mis); end
        checks++; if (in_mis != 0) begin errors++; $display("FAIL a5_sr_in_hold: got %0d wrong cycles expected 0", in_mis); end
        checks++; if ({ck_s[10], ck_s[75]} !== 2'b00) begin errors++; $display("FAIL a5_ck_low_outside_byte: got %b expected 00", {ck_s[10], ck_s[75]}); end
        pat_mis = 0;
        for (int i = 0; i < 8; i++) if (bits[(rb + i) % 8192] !== pat[i]) pat_mis++;
        checks++; if (pat_mis != 0) begin errors++; $display("FAIL a5_sampled_pattern: got %0d wrong bits expected 0", pat_mis); end
        wait_busy_low(8000, n, to);
        checks++; if (to) begin errors++; $display("FAIL a5_timeout: busy still %b expected 0", Out_Busy); end
        checks++; if (end_cnt - eb != 1) begin errors++; $display("FAIL a5_end_pulses: got %0d expected 1", end_cnt - eb); end
        @(negedge Clk);
        $display("test_a5_waveform done");
    endtask

    task automatic test_fifo_gap();
        int rb, bb, eb, n, hi, rd, lo_busy, r_gap;
        bit to;
        flush();
        for (int i = 0; i < 31; i++) push(8'(i * 7 + 3));
        rb = rise_cnt; bb = rd_ptr; eb = end_cnt;
        start_pulse();
        n = 0;
        while (!((rise_cnt - rb) == 248 && !Out_Sr_Ck) && n < 4000) begin
            @(negedge Clk);
            n++;
        end
        checks++; if (n >= 4000) begin errors++; $display("FAIL gap_reach_byte30: got %0d rises expected 248", rise_cnt - rb); end
        r_gap = rise_cnt;
        hi = 0; rd = 0; lo_busy = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (Out_Sr_Ck) hi++;
            if (Out_Ex_Fifo_Rd_En) rd++;
            if (!Out_Busy) lo_busy++;
        end
        checks++; if (hi != 0) begin errors++; $display("FAIL gap_sr_ck_low: got %0d high cycles expected 0", hi); end
        checks++; if (rd != 0) begin errors++; $display("FAIL gap_no_rd_en: got %0d strobes expected 0", rd); end
        checks++; if (lo_busy != 0 || rise_cnt != r_gap) begin errors++; $display("FAIL gap_stall: got busy_low=%0d extra_rises=%0d expected 0 0", lo_busy, rise_cnt - r_gap); end
        for (int i = 31; i < 77; i++) push(8'(i * 7 + 3));
        wait_busy_low(8000, n, to);
        checks++; if (to) begin errors++; $display("FAIL gap_timeout: busy still %b expected 0", Out_Busy); end
        checks++; if (rise_cnt - rb != 616) begin errors++; $display("FAIL gap_rises: got %0d expected 616", rise_cnt - rb); end
        checks++; if (bit_mismatches(rb, bb, 77) != 0) begin errors++; $display("FAIL gap_stream: got %0d bit errors expected 0", bit_mismatches(rb, bb, 77)); end
        checks++; if (end_cnt - eb != 1 || Out_Err !== 1'b0) begin errors++; $display("FAIL gap_end: got pulses=%0d err=%b expected 1 0", end_cnt - eb, Out_Err); end
        @(negedge Clk);
        $display("test_fifo_gap done");
    endtask

    task automatic test_underflow();
        int rb, bb, eb, re, n;
        bit to;
        flush();
        for (int i = 0; i < 10; i++) push(8'(i) ^ 8'h5A);
        rb = rise_cnt; bb = rd_ptr; eb = end_cnt; re = rd_empty_cnt;
        start_pulse();
        wait_busy_low(3000, n, to);
        checks++; if (to) begin errors++; $display("FAIL under_timeout: busy still %b expected 0", Out_Busy); end
        // 8 reset cycles + 10 bytes * 66 + 1024 empty fetch cycles
        checks++; if (n != 1692) begin errors++; $display("FAIL under_busy_cycles: got %0d expected 1692", n); end
        checks++; if ({Out_Err, End_Flag, Out_Select} !== 3'b100) begin errors++; $display("FAIL under_err_state: got err/end/sel=%b expected 100", {Out_Err, End_Flag, Out_Select}); end
        checks++; if (rise_cnt - rb != 80) begin errors++; $display("FAIL under_rises: got %0d expected 80", rise_cnt - rb); end
        checks++; if (bit_mismatches(rb, bb, 10) != 0) begin errors++; $display("FAIL under_stream: got %0d bit errors expected 0", bit_mismatches(rb, bb, 10)); end
        repeat (3) @(negedge Clk);
        checks++; if ({Out_Err, Out_Busy} !== 2'b10) begin errors++; $display("FAIL under_err_sticky: got err/busy=%b expected 10", {Out_Err, Out_Busy}); end
        checks++; if (end_cnt - eb != 0 || rd_empty_cnt - re != 0) begin errors++; $display("FAIL under_no_end_no_bad_pop: got end=%0d badpop=%0d expected 0 0", end_cnt - eb, rd_empty_cnt - re); end
        for (int i = 0; i < 77; i++) push(8'(i + 100));
        eb = end_cnt;
        start_pulse();
        checks++; if ({Out_Err, Out_Busy} !== 2'b01) begin errors++; $display("FAIL under_restart_clears_err: got err/busy=%b expected 01", {Out_Err, Out_Busy}); end
        wait_busy_low(8000, n, to);
        checks++; if (to || end_cnt - eb != 1) begin errors++; $display("FAIL under_restart_completes: got end=%0d busy=%b expected 1 0", end_cnt - eb, Out_Busy); end
        @(negedge Clk);
        $display("test_underflow done");
    endtask

    task automatic test_double_start();
        int rb, bb, eb, n;
        bit to;
        flush();
        for (int i = 0; i < 77; i++) push(8'(i * 3));
        rb = rise_cnt; bb = rd_ptr; eb = end_cnt;
        start_pulse();
        wait_rises(160, rb, 4000, to);
        checks++; if (to) begin errors++; $display("FAIL dbl_reach_byte20: got %0d rises expected 160", rise_cnt - rb); end
        Start_In = 1'b1;
        repeat (2) @(negedge Clk);
        Start_In = 1'b0;
        checks++; if (Out_Busy !== 1'b1) begin errors++; $display("FAIL dbl_still_busy: got %b expected 1", Out_Busy); end
        wait_busy_low(8000, n, to);
        checks++; if (to) begin errors++; $display("FAIL dbl_timeout: busy still %b expected 0", Out_Busy); end
        checks++; if (rise_cnt - rb != 616) begin errors++; $display("FAIL dbl_rises: got %0d expected 616", rise_cnt - rb); end
        checks++; if (bit_mismatches(rb, bb, 77) != 0) begin errors++; $display("FAIL dbl_stream: got %0d bit errors expected 0", bit_mismatches(rb, bb, 77)); end
        repeat (3) @(negedge Clk);
        checks++; if (end_cnt - eb != 1 || Out_Busy !== 1'b0) begin errors++; $display("FAIL dbl_single_end: got end=%0d busy=%b expected 1 0", end_cnt - eb, Out_Busy); end
        $display("test_double_start done");
    endtask

    task automatic test_reset_mid();
        int rb, bb, eb, p, n;
        bit to;
        flush();
        for (int i = 0; i < 77; i++) push(8'hFF - 8'(i));
        rb = rise_cnt;
        start_pulse();
        wait_rises(323, rb, 6000, to);
        checks++; if (to) begin errors++; $display("FAIL rstmid_reach_byte40: got %0d rises expected 323", rise_cnt - rb); end
        p = pop_cnt;
        Rst = 1'b1;
        @(negedge Clk);
        // {rd_en, sr_ck, sr_in, sr_rstb, select, busy, err, end_flag}
        checks++; if ({Out_Ex_Fifo_Rd_En, Out_Sr_Ck, Out_Sr_In, Out_Sr_Rstb, Out_Select, Out_Busy, Out_Err, End_Flag} !== 8'b0001_0000)
            begin errors++; $display("FAIL rstmid_outputs: got %b expected 00010000", {Out_Ex_Fifo_Rd_En, Out_Sr_Ck, Out_Sr_In, Out_Sr_Rstb, Out_Select, Out_Busy, Out_Err, End_Flag}); end
        @(negedge Clk);
        Rst = 1'b0;
        repeat (3) @(negedge Clk);
        checks++; if (pop_cnt != p || Out_Busy !== 1'b0) begin errors++; $display("FAIL rstmid_no_pop_idle: got pops=%0d busy=%b expected 0 0", pop_cnt - p, Out_Busy); end
        flush();
        for (int i = 0; i < 77; i++) push(8'(i) ^ 8'hC3);
        rb = rise_cnt; bb = rd_ptr; eb = end_cnt;
        start_pulse();
        wait_busy_low(8000, n, to);
        checks++; if (to) begin errors++; $display("FAIL rstmid_timeout: busy still %b expected 0", Out_Busy); end
        checks++; if (rise_cnt - rb != 616) begin errors++; $display("FAIL rstmid_rises: got %0d expected 616", rise_cnt - rb); end
        checks++; if (bit_mismatches(rb, bb, 77) != 0) begin errors++; $display("FAIL rstmid_stream: got %0d bit errors expected 0", bit_mismatches(rb, bb, 77)); end
        checks++; if (end_cnt - eb != 1 || Out_Err !== 1'b0) begin errors++; $display("FAIL rstmid_end: got end=%0d err=%b expected 1 0", end_cnt - eb, Out_Err); end
        @(negedge Clk);
        $display("test_reset_mid done");
    endtask

    initial begin
        Rst = 1'b1;
        Start_In = 1'b0;
        @(negedge Clk);
        test_reset();
        test_full_load();
        test_a5_waveform();
        test_fifo_gap();
        test_underflow();
        test_double_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
